// File: rtl/mips_pkg.sv
// mips_pkg: shared immediate-extension modes and default operand source indices
package mips_pkg;
   localparam logic [1:0] EXT_SIGN  = 2'd0;
   localparam logic [1:0] EXT_ZERO  = 2'd1;
   localparam logic [1:0] EXT_SHL2  = 2'd2;
   localparam logic [1:0] EXT_UPPER = 2'd3;
   localparam int SRC_B     = 0;
   localparam int SRC_CONST = 1;
   localparam int SRC_IMM   = 2;
   localparam int SRC_ADDR  = 3;
endpackage

// File: rtl/operand_skid_buffer.sv
// operand_skid_buffer: two-entry valid/ready register slice (output register plus one skid entry)
module operand_skid_buffer #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             i_valid,
   output logic             o_ready,
   input  logic [WIDTH-1:0] i_data,
   output logic             o_valid,
   input  logic             i_ready,
   output logic [WIDTH-1:0] o_data
);
   logic             r_out_valid;
   logic             r_skid_full;
   logic [WIDTH-1:0] r_out_data;
   logic [WIDTH-1:0] r_skid_data;
   logic             w_in_xfer;
   logic             w_load_out;
   assign w_in_xfer  = i_valid && !r_skid_full;
   assign w_load_out = !r_out_valid || i_ready;
   assign o_ready    = !r_skid_full;
   assign o_valid    = r_out_valid;
   assign o_data     = r_out_data;
   // output register refills from skid first (FIFO order); new data parks in skid only while output stalls
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_out_valid <= 1'b0;
         r_skid_full <= 1'b0;
         r_out_data  <= '0;
         r_skid_data <= '0;
      end else if (w_load_out) begin
         r_out_valid <= r_skid_full || w_in_xfer;
         r_out_data  <= r_skid_full ? r_skid_data : w_in_xfer ? i_data : r_out_data;
         r_skid_full <= 1'b0;
      end else if (w_in_xfer) begin
         r_skid_full <= 1'b1;
         r_skid_data <= i_data;
      end
   end
endmodule

// File: rtl/alu_operand_select_pipe.sv
// alu_operand_select_pipe: registered ALU source-B operand select with immediate extension and skid buffer
module alu_operand_select_pipe
   import mips_pkg::*;
#(
   parameter  int          WIDTH     = 32,
   parameter  int          NUM_SRC   = 4,
   localparam int          SEL_W     = $clog2(NUM_SRC),
   parameter  int          IMM_W     = 16,
   parameter  int          CONST_IDX = SRC_CONST,
   parameter  int unsigned CONST_VAL = 4,
   parameter  int          EXT_IDX   = SRC_IMM
) (
   input  logic                     clk,
   input  logic                     reset_n,
   input  logic                     in_valid,
   output logic                     in_ready,
   input  logic [SEL_W-1:0]         sel,
   input  logic [NUM_SRC*WIDTH-1:0] src_bus,
   input  logic [IMM_W-1:0]         imm,
   input  logic [1:0]               ext_mode,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic [WIDTH-1:0]         out_data,
   output logic                     err_sel
);
   localparam logic [SEL_W-1:0] L_CONST_SEL = SEL_W'(CONST_IDX);
   localparam logic [SEL_W-1:0] L_EXT_SEL   = SEL_W'(EXT_IDX);
   localparam logic [WIDTH-1:0] L_CONST_VAL = WIDTH'(CONST_VAL);
   logic [WIDTH-1:0] w_slice;
   logic [WIDTH-1:0] w_sext;
   logic [WIDTH-1:0] w_zext;
   logic [WIDTH-1:0] w_upper;
   logic [WIDTH-1:0] w_ext;
   logic [WIDTH-1:0] w_sel_data;
   logic             w_bad;
   logic             w_in_ready;
   logic             r_err_sel;
   assign w_bad    = 32'(sel) >= 32'(NUM_SRC);
   assign w_slice  = WIDTH'(src_bus >> (32'(sel) * 32'(WIDTH)));
   assign w_sext   = {{(WIDTH-IMM_W){imm[IMM_W-1]}}, imm};
   assign w_zext   = {{(WIDTH-IMM_W){1'b0}}, imm};
   assign w_upper  = {imm, {(WIDTH-IMM_W){1'b0}}};
   assign in_ready = w_in_ready;
   assign err_sel  = r_err_sel;
   // extend the immediate, then pick the operand; out-of-range selects yield zero
   always_comb begin
      w_ext      = ext_mode == EXT_SIGN ? w_sext :
                   ext_mode == EXT_ZERO ? w_zext :
                   ext_mode == EXT_SHL2 ? (w_sext << 2) : w_upper;
      w_sel_data = w_bad                ? '0 :
                   sel == L_CONST_SEL   ? L_CONST_VAL :
                   sel == L_EXT_SEL     ? w_ext : w_slice;
   end
   // sticky error: any accepted out-of-range select latches until reset
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) r_err_sel <= 1'b0;
      else if (in_valid && w_in_ready && w_bad) r_err_sel <= 1'b1;
   end
   operand_skid_buffer #(.WIDTH(WIDTH)) u_skid (
      .clk     (clk),
      .reset_n (reset_n),
      .i_valid (in_valid),
      .o_ready (w_in_ready),
      .i_data  (w_sel_data),
      .o_valid (out_valid),
      .i_ready (out_ready),
      .o_data  (out_data)
   );
endmodule

// File: tb/tb_alu_operand_select_pipe.sv
// tb_alu_operand_select_pipe: scoreboard bench with a behavioural operand model
module tb_alu_operand_select_pipe;
   logic         clk = 1'b0;
   logic         reset_n;
   logic         in_valid;
   logic         in_ready;
   logic [1:0]   sel;
   logic [127:0] src_bus;
   logic [15:0]  imm;
   logic [1:0]   ext_mode;
   logic         out_valid;
   logic         out_ready;
   logic [31:0]  out_data;
   logic         err_sel;
   logic [31:0]  src_arr [4];
   logic         reset5_n;
   logic         in_valid5;
   logic         in_ready5;
   logic [2:0]   sel5;
   logic [159:0] src5;
   logic         out_valid5;
   logic         out_ready5;
   logic [31:0]  out5;
   logic         err5;
   logic [31:0]  exp_q [$];
   int tests = 0;
   int fails = 0;

   always #5 clk = ~clk;

   always_comb src_bus = {src_arr[3], src_arr[2], src_arr[1], src_arr[0]};

   alu_operand_select_pipe dut (
      .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready),
      .sel(sel), .src_bus(src_bus), .imm(imm), .ext_mode(ext_mode),
      .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .err_sel(err_sel)
   );

   alu_operand_select_pipe #(.NUM_SRC(5)) dut5 (
      .clk(clk), .reset_n(reset5_n), .in_valid(in_valid5), .in_ready(in_ready5),
      .sel(sel5), .src_bus(src5), .imm(16'h0001), .ext_mode(2'd0),
      .out_valid(out_valid5), .out_ready(out_ready5), .out_data(out5), .err_sel(err5)
   );

   function automatic void chk(string nm, logic [31:0] act, logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endfunction

   // operand value from the select rules, computed arithmetically
   function automatic logic [31:0] model(int s, logic [31:0] slice, int unsigned im, int md);
      longint v;
      if (s >= 4) return 32'h0;
      if (s == 1) return 32'd4;
      if (s != 2) return slice;
      v = (im >= 32768) ? longint'(im) - 65536 : longint'(im);
      case (md)
         0: return v[31:0];
         1: return im;
         2: begin v = v * 4; return v[31:0]; end
         default: begin v = longint'(im) * 65536; return v[31:0]; end
      endcase
   endfunction

   task automatic cycle(output bit acc);
      @(negedge clk);
      acc = in_valid && in_ready;
      if (acc) exp_q.push_back(model(int'(sel), src_arr[sel], 32'(imm), int'(ext_mode)));
      @(posedge clk);
      #1;
   endtask

   task automatic send(input logic [1:0] s, input logic [1:0] md, input logic [15:0] im);
      bit acc;
      acc = 1'b0;
      in_valid = 1'b1;
      sel = s;
      ext_mode = md;
      imm = im;
      for (int n = 0; n < 50 && !acc; n++) cycle(acc);
      if (!acc) begin
         tests++;
         fails++;
         $display("FAIL send_timeout: got no acceptance expected acceptance within 50 cycles");
      end
      in_valid = 1'b0;
   endtask

   task automatic drain();
      bit acc;
      in_valid = 1'b0;
      out_ready = 1'b1;
      for (int n = 0; n < 20 && exp_q.size() != 0; n++) cycle(acc);
      chk("drain_empty", 32'(exp_q.size()), 32'd0);
   endtask

   // monitor: pops expected operands on every output transfer and checks stall stability
   initial begin
      logic [31:0] held;
      bit hv;
      hv = 1'b0;
      held = '0;
      forever begin
         @(negedge clk);
         if (!reset_n) hv = 1'b0;
         else begin
            if (hv) begin
               chk("hold_valid", 32'(out_valid), 32'd1);
               chk("hold_data", out_data, held);
            end
            hv = out_valid && !out_ready;
            held = out_data;
            if (out_valid && out_ready) begin
               if (exp_q.size() == 0) begin
                  tests++;
                  fails++;
                  $display("FAIL unexpected_out: got %h expected no operand", out_data);
               end else chk("sb_data", out_data, exp_q.pop_front());
            end
         end
      end
   end

   initial begin
      bit acc;
      reset_n = 1'b0; reset5_n = 1'b0;
      in_valid = 1'b0; in_valid5 = 1'b0; out_ready = 1'b0; out_ready5 = 1'b1;
      sel = '0; sel5 = '0; imm = '0; ext_mode = '0; src5 = '0;
      for (int k = 0; k < 4; k++) src_arr[k] = '0;
      #1;
      chk("rst_out_valid", 32'(out_valid), 32'd0);
      chk("rst_out_data", out_data, 32'd0);
      chk("rst_in_ready", 32'(in_ready), 32'd1);
      chk("rst_err_sel", 32'(err_sel), 32'd0);
      @(posedge clk); #1;
      reset_n = 1'b1; reset5_n = 1'b1;
      repeat (2) cycle(acc);
      chk("rel_out_valid", 32'(out_valid), 32'd0);
      chk("rel_out_data", out_data, 32'd0);
      chk("rel_in_ready", 32'(in_ready), 32'd1);
      // back-to-back selects
      out_ready = 1'b1;
      src_arr[0] = 32'h00000011; src_arr[1] = 32'hDEADBEEF; src_arr[2] = 32'h0; src_arr[3] = 32'h12345678;
      send(2'd0, 2'd0, 16'h0);
      chk("b2b_sel0", out_data, 32'h00000011);
      chk("b2b_valid", 32'(out_valid), 32'd1);
      send(2'd1, 2'd0, 16'h0);
      chk("b2b_sel1", out_data, 32'h00000004);
      send(2'd3, 2'd0, 16'h0);
      chk("b2b_sel3", out_data, 32'h12345678);
      // immediate extension modes
      send(2'd2, 2'd0, 16'h8004); chk("ext_sign", out_data, 32'hFFFF8004);
      send(2'd2, 2'd1, 16'h8004); chk("ext_zero", out_data, 32'h00008004);
      send(2'd2, 2'd2, 16'h8004); chk("ext_shl2", out_data, 32'hFFFE0010);
      send(2'd2, 2'd3, 16'h8004); chk("ext_upper", out_data, 32'h80040000);
      cycle(acc);
      // stall fills both entries, third request held off
      out_ready = 1'b0;
      src_arr[0] = 32'h1; send(2'd0, 2'd0, 16'h0);
      chk("stall_a", out_data, 32'h1);
      src_arr[0] = 32'h2; send(2'd0, 2'd0, 16'h0);
      chk("stall_in_ready", 32'(in_ready), 32'd0);
      chk("stall_a_kept", out_data, 32'h1);
      src_arr[0] = 32'h3; in_valid = 1'b1; sel = 2'd0;
      for (int n = 0; n < 3; n++) begin
         cycle(acc);
         chk("c_held_off", 32'(acc), 32'd0);
      end
      chk("stall_out_data", out_data, 32'h1);
      out_ready = 1'b1;
      send(2'd0, 2'd0, 16'h0);
      chk("stall_c_out", out_data, 32'h3);
      drain();
      // randomized traffic with random back-pressure
      for (int i = 0; i < 400; i++) begin
         out_ready = ($urandom_range(0, 3) != 0);
         for (int k = 0; k < 4; k++) src_arr[k] = $urandom;
         in_valid = ($urandom_range(0, 2) != 0);
         sel = 2'($urandom_range(0, 3));
         imm = 16'($urandom);
         ext_mode = 2'($urandom_range(0, 3));
         cycle(acc);
      end
      drain();
      chk("err_sel_clean", 32'(err_sel), 32'd0);
      // reset while both entries are full
      out_ready = 1'b0;
      src_arr[0] = 32'hAA; send(2'd0, 2'd0, 16'h0);
      src_arr[0] = 32'hBB; send(2'd0, 2'd0, 16'h0);
      #2;
      reset_n = 1'b0;
      #1;
      chk("midrst_out_valid", 32'(out_valid), 32'd0);
      chk("midrst_in_ready", 32'(in_ready), 32'd1);
      exp_q.delete();
      @(posedge clk); #1;
      reset_n = 1'b1;
      out_ready = 1'b1;
      repeat (2) cycle(acc);
      chk("no_stale", 32'(out_valid), 32'd0);
      src_arr[0] = 32'h55; send(2'd0, 2'd0, 16'h0);
      chk("post_rst_data", out_data, 32'h55);
      chk("post_rst_valid", 32'(out_valid), 32'd1);
      drain();
      // five-source instance: out-of-range select and sticky error
      src5[31:0] = 32'hA5A5;
      chk("n5_in_ready", 32'(in_ready5), 32'd1);
      in_valid5 = 1'b1; sel5 = 3'd6;
      @(posedge clk); #1;
      chk("n5_bad_data", out5, 32'h0);
      chk("n5_bad_valid", 32'(out_valid5), 32'd1);
      chk("n5_err_set", 32'(err5), 32'd1);
      sel5 = 3'd0;
      @(posedge clk); #1;
      chk("n5_src0", out5, 32'hA5A5);
      chk("n5_err_sticky", 32'(err5), 32'd1);
      sel5 = 3'd2;
      @(posedge clk); #1;
      chk("n5_ext", out5, 32'h1);
      chk("n5_err_sticky2", 32'(err5), 32'd1);
      in_valid5 = 1'b0;
      reset5_n = 1'b0;
      #1;
      chk("n5_err_clear", 32'(err5), 32'd0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
